// File: rtl/sifh_hist_sequencer.sv
// Histogram frame sequencer: clears the bin RAM, accumulates ToF samples per pixel with
// read-modify-write forwarding, then scans every pixel for its peak bin.
module sifh_hist_sequencer #(
    parameter int BIN_W        = 6,
    parameter int PIX_W        = 2,
    parameter int CNT_W        = 8,
    parameter int SAMP_PER_PIX = 1000
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     tof_valid,
    input  logic [BIN_W-1:0]         tof_bin,
    output logic                     tof_ready,
    output logic [PIX_W+BIN_W-1:0]   raddr,
    output logic                     ren,
    input  logic [CNT_W-1:0]         rdata,
    output logic [PIX_W+BIN_W-1:0]   waddr,
    output logic                     wen,
    output logic [CNT_W-1:0]         wdata,
    output logic                     peak_valid,
    output logic [PIX_W-1:0]         peak_pix,
    output logic [BIN_W-1:0]         peak_bin,
    output logic [CNT_W-1:0]         peak_cnt,
    output logic                     busy,
    output logic                     done
);

    localparam int ADDR_W = PIX_W + BIN_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_ACQ    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_SEARCH = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [BIN_W-1:0]  BIN_LAST  = {BIN_W{1'b1}};
    localparam logic [PIX_W-1:0]  PIX_LAST  = {PIX_W{1'b1}};
    localparam logic [15:0]       SAMP_LAST = 16'(SAMP_PER_PIX - 1);

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            f_sat_inc = v;
        end else begin
            f_sat_inc = v + CNT_W'(1'b1);
        end
    endfunction

    logic [2:0]        r_state;
    logic [PIX_W-1:0]  r_pix;
    logic [15:0]       r_samp;
    logic              r_p1_vld;
    logic [ADDR_W-1:0] r_p1_addr;
    logic              r_p2_vld;
    logic [ADDR_W-1:0] r_p2_addr;
    logic              r_wen_d;
    logic [ADDR_W-1:0] r_waddr_d;
    logic [CNT_W-1:0]  r_wdata_d;
    logic [ADDR_W:0]   r_scnt;
    logic [CNT_W-1:0]  r_max_cnt;
    logic [BIN_W-1:0]  r_max_bin;

    logic              w_accept;
    logic [CNT_W-1:0]  w_old;
    logic [CNT_W-1:0]  w_cand_cnt;
    logic [BIN_W-1:0]  w_cand_bin;
    logic [BIN_W-1:0]  w_p2_bin;
    logic [PIX_W-1:0]  w_p2_pix;

    assign w_accept = (r_state == S_ACQ) & tof_valid & tof_ready;
    assign w_p2_bin = r_p2_addr[BIN_W-1:0];
    assign w_p2_pix = r_p2_addr[ADDR_W-1:BIN_W];

    // Old count for the write stage: the RAM has not yet absorbed the writes of the last two cycles.
    always_comb begin
        w_old = rdata;
        if (wen && (waddr == r_p2_addr)) begin
            w_old = wdata;
        end else if (r_wen_d && (r_waddr_d == r_p2_addr)) begin
            w_old = r_wdata_d;
        end else begin
            w_old = rdata;
        end
    end

    // Running maximum during the peak scan; bin 0 restarts the search for each pixel.
    always_comb begin
        w_cand_cnt = r_max_cnt;
        w_cand_bin = r_max_bin;
        if (w_p2_bin == {BIN_W{1'b0}}) begin
            w_cand_cnt = rdata;
            w_cand_bin = w_p2_bin;
        end else if (rdata > r_max_cnt) begin
            w_cand_cnt = rdata;
            w_cand_bin = w_p2_bin;
        end else begin
            w_cand_cnt = r_max_cnt;
            w_cand_bin = r_max_bin;
        end
    end

    // Frame sequencer, RAM port drivers and two-stage read pipeline shared by ACQ and SEARCH.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state    <= S_IDLE;
            r_pix      <= {PIX_W{1'b0}};
            r_samp     <= 16'd0;
            r_p1_vld   <= 1'b0;
            r_p1_addr  <= {ADDR_W{1'b0}};
            r_p2_vld   <= 1'b0;
            r_p2_addr  <= {ADDR_W{1'b0}};
            r_wen_d    <= 1'b0;
            r_waddr_d  <= {ADDR_W{1'b0}};
            r_wdata_d  <= {CNT_W{1'b0}};
            r_scnt     <= {(ADDR_W+1){1'b0}};
            r_max_cnt  <= {CNT_W{1'b0}};
            r_max_bin  <= {BIN_W{1'b0}};
            tof_ready  <= 1'b0;
            raddr      <= {ADDR_W{1'b0}};
            ren        <= 1'b0;
            waddr      <= {ADDR_W{1'b0}};
            wen        <= 1'b0;
            wdata      <= {CNT_W{1'b0}};
            peak_valid <= 1'b0;
            peak_pix   <= {PIX_W{1'b0}};
            peak_bin   <= {BIN_W{1'b0}};
            peak_cnt   <= {CNT_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_p1_vld   <= 1'b0;
            r_p2_vld   <= 1'b0;
            r_wen_d    <= 1'b0;
            tof_ready  <= 1'b0;
            ren        <= 1'b0;
            wen        <= 1'b0;
            peak_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ren        <= 1'b0;
            wen        <= 1'b0;
            peak_valid <= 1'b0;
            done       <= 1'b0;
            r_wen_d    <= wen;
            r_waddr_d  <= waddr;
            r_wdata_d  <= wdata;
            r_p1_vld   <= 1'b0;
            r_p2_vld   <= r_p1_vld;
            r_p2_addr  <= r_p1_addr;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLEAR;
                        busy    <= 1'b1;
                        wen     <= 1'b1;
                        waddr   <= {ADDR_W{1'b0}};
                        wdata   <= {CNT_W{1'b0}};
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (waddr == ADDR_LAST) begin
                        r_state   <= S_ACQ;
                        tof_ready <= 1'b1;
                        r_pix     <= {PIX_W{1'b0}};
                        r_samp    <= 16'd0;
                    end else begin
                        wen       <= 1'b1;
                        waddr     <= waddr + ADDR_W'(1'b1);
                        wdata     <= {CNT_W{1'b0}};
                    end
                end
                S_ACQ, S_DRAIN: begin
                    if (w_accept) begin
                        ren       <= 1'b1;
                        raddr     <= {r_pix, tof_bin};
                        r_p1_vld  <= 1'b1;
                        r_p1_addr <= {r_pix, tof_bin};
                        if (r_samp == SAMP_LAST) begin
                            r_samp <= 16'd0;
                            r_pix  <= r_pix + PIX_W'(1'b1);
                            if (r_pix == PIX_LAST) begin
                                tof_ready <= 1'b0;
                                r_state   <= S_DRAIN;
                            end
                        end else begin
                            r_samp <= r_samp + 16'd1;
                        end
                    end
                    if (r_p2_vld) begin
                        wen   <= 1'b1;
                        waddr <= r_p2_addr;
                        wdata <= f_sat_inc(w_old);
                    end
                    // Both pipeline stages empty means the final write has already been issued.
                    if ((r_state == S_DRAIN) && !r_p1_vld && !r_p2_vld) begin
                        r_state <= S_SEARCH;
                        r_scnt  <= {(ADDR_W+1){1'b0}};
                    end
                end
                S_SEARCH: begin
                    if (!r_scnt[ADDR_W]) begin
                        ren       <= 1'b1;
                        raddr     <= r_scnt[ADDR_W-1:0];
                        r_p1_vld  <= 1'b1;
                        r_p1_addr <= r_scnt[ADDR_W-1:0];
                        r_scnt    <= r_scnt + (ADDR_W+1)'(1'b1);
                    end
                    if (r_p2_vld) begin
                        r_max_cnt <= w_cand_cnt;
                        r_max_bin <= w_cand_bin;
                        if (w_p2_bin == BIN_LAST) begin
                            peak_valid <= 1'b1;
                            peak_pix   <= w_p2_pix;
                            peak_bin   <= w_cand_bin;
                            peak_cnt   <= w_cand_cnt;
                            if (w_p2_pix == PIX_LAST) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    tof_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sifh_hist_sequencer.sv
// Scoreboard bench for sifh_hist_sequencer: a count-array model predicts every RAM write,
// per-pixel peak and done pulse; a negedge monitor pops and compares them.
module tb_sifh_hist_sequencer;

    localparam int BIN_W  = 6;
    localparam int PIX_W  = 2;
    localparam int CNT_W  = 3;
    localparam int SAMP   = 8;
    localparam int ADDR_W = PIX_W + BIN_W;
    localparam int NBIN   = 1 << BIN_W;
    localparam int NPIX   = 1 << PIX_W;
    localparam int NADDR  = 1 << ADDR_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic res, start, abort, tof_valid, tof_ready;
    logic [BIN_W-1:0]  tof_bin;
    logic [ADDR_W-1:0] raddr, waddr;
    logic ren, wen, peak_valid, busy, done;
    logic [CNT_W-1:0]  rdata, wdata, peak_cnt;
    logic [PIX_W-1:0]  peak_pix;
    logic [BIN_W-1:0]  peak_bin;

    int n_checks = 0;
    int n_errors = 0;
    int cnt [NADDR];
    int stim [$];
    int exp_done = 0;
    logic [ADDR_W+CNT_W-1:0]       exp_wr [$];
    logic [PIX_W+BIN_W+CNT_W-1:0]  exp_pk [$];
    logic [ADDR_W+CNT_W-1:0]       e_wr;
    logic [PIX_W+BIN_W+CNT_W-1:0]  e_pk;
    logic [CNT_W-1:0] mem [NADDR];

    always #5 clk = ~clk;

    sifh_hist_sequencer #(.BIN_W(BIN_W), .PIX_W(PIX_W), .CNT_W(CNT_W), .SAMP_PER_PIX(SAMP)) dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .tof_valid(tof_valid), .tof_bin(tof_bin), .tof_ready(tof_ready),
        .raddr(raddr), .ren(ren), .rdata(rdata),
        .waddr(waddr), .wen(wen), .wdata(wdata),
        .peak_valid(peak_valid), .peak_pix(peak_pix), .peak_bin(peak_bin), .peak_cnt(peak_cnt),
        .busy(busy), .done(done)
    );

    // Registered-read, read-first RAM.
    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
        if (wen) mem[waddr] <= wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (res) begin
            check("no_access_when_idle", {63'd0, (!busy && (wen || ren))}, 64'd0);
            if (wen) begin
                if (exp_wr.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_write addr=%0d data=%0d expected none", waddr, wdata);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("write_addr_data", {53'd0, waddr, wdata}, {53'd0, e_wr});
                end
            end
            if (peak_valid) begin
                if (exp_pk.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_peak pix=%0d bin=%0d cnt=%0d expected none", peak_pix, peak_bin, peak_cnt);
                end else begin
                    e_pk = exp_pk.pop_front();
                    check("peak_pix_bin_cnt", {53'd0, peak_pix, peak_bin, peak_cnt}, {53'd0, e_pk});
                end
            end
            if (done) begin
                n_checks++;
                if (exp_done == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    exp_done--;
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {28'd0, tof_ready, ren, wen, peak_valid, busy, done, raddr, waddr, wdata,
                     peak_pix, peak_bin, peak_cnt}, 64'd0);
    endtask

    task automatic build_stim(input bit directed, input int hi);
        stim.delete();
        for (int i = 0; i < NPIX * SAMP; i++) begin
            if (directed && i < SAMP) stim.push_back(5);
            else if (directed && i < 2 * SAMP) stim.push_back((i % 2 == 0) ? 3 : 9);
            else stim.push_back($urandom_range(0, hi));
        end
    endtask

    task automatic start_frame(input bit with_abort);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        for (int a = 0; a < NADDR; a++) begin
            cnt[a] = 0;
            exp_wr.push_back({a[ADDR_W-1:0], {CNT_W{1'b0}}});
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("wen_after_start", {63'd0, wen}, 64'd1);
    endtask

    task automatic feed(input int abort_at, input bit dense);
        int idx = 0;
        int guard = 0;
        int a, b;
        while (idx < stim.size() && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (abort_at >= 0 && idx == abort_at) begin
                tof_valid = 1'b0;
                start = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", {63'd0, busy}, 64'd0);
                check("abort_wen", {63'd0, wen}, 64'd0);
                check("abort_ready", {63'd0, tof_ready}, 64'd0);
                check("abort_done", {63'd0, done}, 64'd0);
                exp_wr.delete();
                return;
            end
            start = ($urandom_range(0, 15) == 0);
            tof_valid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
            b = stim[idx];
            tof_bin = b[BIN_W-1:0];
            if (tof_valid && tof_ready) begin
                a = (idx / SAMP) * NBIN + b;
                if (cnt[a] < CMAX) cnt[a] = cnt[a] + 1;
                exp_wr.push_back({a[ADDR_W-1:0], cnt[a][CNT_W-1:0]});
                idx++;
            end
        end
        if (guard >= 3000) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout accepted=%0d expected=%0d", idx, stim.size());
        end
        @(negedge clk);
        tof_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic push_peaks();
        int bb, bc;
        for (int p = 0; p < NPIX; p++) begin
            bb = 0;
            bc = cnt[p * NBIN];
            for (int b = 1; b < NBIN; b++) begin
                if (cnt[p * NBIN + b] > bc) begin
                    bb = b;
                    bc = cnt[p * NBIN + b];
                end
            end
            exp_pk.push_back({p[PIX_W-1:0], bb[BIN_W-1:0], bc[CNT_W-1:0]});
        end
        exp_done = exp_done + 1;
    endtask

    task automatic finish_frame();
        int guard = 0;
        push_peaks();
        while ((exp_pk.size() != 0 || exp_done != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++; n_errors++;
            $display("FAIL frame_timeout pending_peaks=%0d pending_done=%0d expected 0", exp_pk.size(), exp_done);
            exp_pk.delete();
            exp_done = 0;
        end
        @(negedge clk);
        check("writes_all_seen", 64'(exp_wr.size()), 64'd0);
        check("busy_back_to_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic reset_in_search();
        int guard = 0;
        push_peaks();
        while (exp_pk.size() == NPIX && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++; n_errors++;
            $display("FAIL search_timeout peaks_seen=0 expected>=1");
        end
        #2 res = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        exp_pk.delete();
        exp_wr.delete();
        exp_done = 0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired time=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NADDR; i++) mem[i] = CNT_W'($urandom);
        res = 1'b0; start = 1'b0; abort = 1'b0; tof_valid = 1'b0; tof_bin = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        res = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle_outputs");

        // Saturating same-bin burst, tie resolution, then random pixels.
        build_stim(1'b1, NBIN - 1);
        start_frame(1'b0); feed(-1, 1'b1); finish_frame();
        check("ram_bin5_saturated", 64'(mem[5]), 64'(CMAX));
        check("ram_tie_bin3", 64'(mem[NBIN + 3]), 64'd4);
        check("ram_tie_bin9", 64'(mem[NBIN + 9]), 64'd4);

        build_stim(1'b0, NBIN - 1);
        start_frame(1'b0); feed(-1, 1'b0); finish_frame();

        build_stim(1'b0, 3);
        start_frame(1'b1); feed(-1, 1'b0); finish_frame();

        build_stim(1'b0, 15);
        start_frame(1'b0); feed(10, 1'b0);
        repeat (10) @(negedge clk);
        check("after_abort_busy", {63'd0, busy}, 64'd0);

        build_stim(1'b0, 15);
        start_frame(1'b0); feed(-1, 1'b0); finish_frame();

        build_stim(1'b0, 7);
        start_frame(1'b0); feed(-1, 1'b1); reset_in_search();

        build_stim(1'b0, 7);
        start_frame(1'b0); feed(-1, 1'b0); finish_frame();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
